// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: central stall/flush scheduler for the 5-stage MIPS pipeline.
// Drives write-enable and flush (bubble-load) controls for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. Outputs are Mealy (state + inputs).
// Optional stall-cycle counter enabled by defining PIPE_HAZARD_STALL_CNT_EN;
// without it o_stall_cnt is tied to zero.
module pipe_hazard_sched #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_load_use,
    input  logic             i_branch_taken,
    input  logic             i_mem_busy,
    input  logic             i_halt,
    output logic             o_pc_we,
    output logic             o_ifid_we,
    output logic             o_idex_we,
    output logic             o_exmem_we,
    output logic             o_memwb_we,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_memwb_flush,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Drain counter only has to hold DRAIN_CYCLES-1.
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [DRN_W-1:0] drain_cnt_r;
    logic [DRN_W-1:0] drain_cnt_nxt_s;
    logic             stall_s;

    // Mealy output decode and next-state/drain-counter selection.
    always_comb begin
        o_pc_we         = 1'b0;
        o_ifid_we       = 1'b0;
        o_idex_we       = 1'b0;
        o_exmem_we      = 1'b0;
        o_memwb_we      = 1'b0;
        o_ifid_flush    = 1'b0;
        o_idex_flush    = 1'b0;
        o_exmem_flush   = 1'b0;
        o_memwb_flush   = 1'b0;
        o_halted        = 1'b0;
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                // PC loads its boot value only once reset has been released.
                o_pc_we       = i_RST_N;
                o_ifid_flush  = 1'b1;
                o_idex_flush  = 1'b1;
                o_exmem_flush = 1'b1;
                o_memwb_flush = 1'b1;
                state_nxt_s   = ST_RUN;
            end
            ST_RUN: begin
                if (i_mem_busy) begin
                    // Freeze everything up to MEM; WB receives a bubble.
                    o_memwb_flush = 1'b1;
                end else if (i_load_use) begin
                    // Hold IF/ID, insert a bubble into EX; branch operand not ready.
                    o_idex_flush = 1'b1;
                    o_exmem_we   = 1'b1;
                    o_memwb_we   = 1'b1;
                end else if (i_halt) begin
                    o_ifid_flush    = 1'b1;
                    o_idex_we       = 1'b1;
                    o_exmem_we      = 1'b1;
                    o_memwb_we      = 1'b1;
                    drain_cnt_nxt_s = DRN_LOAD;
                    state_nxt_s     = ST_DRAIN;
                end else if (i_branch_taken) begin
                    // Redirect PC and squash the wrong-path fetch.
                    o_pc_we      = 1'b1;
                    o_ifid_flush = 1'b1;
                    o_idex_we    = 1'b1;
                    o_exmem_we   = 1'b1;
                    o_memwb_we   = 1'b1;
                end else begin
                    o_pc_we    = 1'b1;
                    o_ifid_we  = 1'b1;
                    o_idex_we  = 1'b1;
                    o_exmem_we = 1'b1;
                    o_memwb_we = 1'b1;
                end
            end
            ST_DRAIN: begin
                o_ifid_flush = 1'b1;
                if (i_mem_busy) begin
                    o_memwb_flush = 1'b1;
                end else begin
                    // ID/EX takes bubbles so no new work follows the halt.
                    o_idex_flush = 1'b1;
                    o_exmem_we   = 1'b1;
                    o_memwb_we   = 1'b1;
                    if (drain_cnt_r == {DRN_W{1'b0}}) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        drain_cnt_nxt_s = drain_cnt_r - DRN_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                o_halted = 1'b1;
            end
            default: begin
                o_ifid_flush  = 1'b1;
                o_idex_flush  = 1'b1;
                o_exmem_flush = 1'b1;
                o_memwb_flush = 1'b1;
                state_nxt_s   = ST_CLEAR;
            end
        endcase
    end

    // A stall cycle is any RUN/DRAIN cycle where the PC is held or memory is busy.
    always_comb begin
        if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
            stall_s = (!o_pc_we) || i_mem_busy;
        end else begin
            stall_s = 1'b0;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_r     <= ST_CLEAR;
            drain_cnt_r <= {DRN_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating stall-cycle counter.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`else
    logic unused_stall_s;
    assign unused_stall_s = stall_s;
    assign o_stall_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Scoreboard bench for pipe_hazard_sched: directed rows push hand-computed
// expected controls; a negedge monitor pops and compares.
module tb_pipe_hazard_sched;

    localparam int TB_CNT_W = 4;
    localparam logic [TB_CNT_W-1:0] CNT_MAX = {TB_CNT_W{1'b1}};

    // Vector order: pc,ifid,idex,exmem,memwb we | ifid,idex,exmem,memwb flush | halted
    localparam logic [9:0] V_RST   = 10'b00000_1111_0;
    localparam logic [9:0] V_CLR   = 10'b10000_1111_0;
    localparam logic [9:0] V_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] V_BUSY  = 10'b00000_0001_0;
    localparam logic [9:0] V_LU    = 10'b00011_0100_0;
    localparam logic [9:0] V_HALT  = 10'b00111_1000_0;
    localparam logic [9:0] V_BR    = 10'b10111_1000_0;
    localparam logic [9:0] V_DRN   = 10'b00011_1100_0;
    localparam logic [9:0] V_DRNB  = 10'b00000_1001_0;
    localparam logic [9:0] V_HLTD  = 10'b00000_0000_1;

    logic i_CLK = 1'b0;
    logic i_RST_N;
    logic i_load_use, i_branch_taken, i_mem_busy, i_halt;
    logic o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we;
    logic o_ifid_flush, o_idex_flush, o_exmem_flush, o_memwb_flush, o_halted;
    logic [TB_CNT_W-1:0] o_stall_cnt;
    logic [9:0] act_vec;

    typedef struct packed {
        logic [9:0]          vec;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;

    pipe_hazard_sched #(.DRAIN_CYCLES(3), .CNT_W(TB_CNT_W)) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N),
        .i_load_use(i_load_use), .i_branch_taken(i_branch_taken),
        .i_mem_busy(i_mem_busy), .i_halt(i_halt),
        .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we), .o_idex_we(o_idex_we),
        .o_exmem_we(o_exmem_we), .o_memwb_we(o_memwb_we),
        .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
        .o_exmem_flush(o_exmem_flush), .o_memwb_flush(o_memwb_flush),
        .o_halted(o_halted), .o_stall_cnt(o_stall_cnt)
    );

    assign act_vec = {o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we,
                      o_ifid_flush, o_idex_flush, o_exmem_flush, o_memwb_flush, o_halted};

    always #5 i_CLK = ~i_CLK;

    // One row per cycle: drive inputs just after posedge, queue expectation, advance.
    task automatic step(input logic rst, input logic ld, input logic br,
                        input logic busy, input logic hlt, input logic [9:0] ev,
                        input bit inc, input string nm);
        exp_t e;
        i_RST_N        = rst;
        i_load_use     = ld;
        i_branch_taken = br;
        i_mem_busy     = busy;
        i_halt         = hlt;
        if (!rst) exp_cnt = '0;
        e.vec = ev;
`ifdef PIPE_HAZARD_STALL_CNT_EN
        e.cnt = exp_cnt;
`else
        e.cnt = '0;
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (inc && rst) exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1'b1;
        @(posedge i_CLK);
        #1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each negedge.
    always @(negedge i_CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            if (act_vec !== e.vec) begin
                fails++;
                $display("FAIL %s ctrl: got %b required %b", nm, act_vec, e.vec);
            end
            tests++;
            if (o_stall_cnt !== e.cnt) begin
                fails++;
                $display("FAIL %s stall_cnt: got %0d required %0d", nm, o_stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        i_RST_N = 1'b1; i_load_use = 1'b0; i_branch_taken = 1'b0;
        i_mem_busy = 1'b0; i_halt = 1'b0;
        #2 i_RST_N = 1'b0;
        @(posedge i_CLK); #1;
        //     rst   ld    br    busy  halt  expected inc name
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RST,  0, "reset");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_CLR,  0, "clear");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN,  0, "run");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V_LU,   1, "lu_over_br");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, V_BR,   0, "branch");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN,  0, "run2");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, V_BUSY, 1, "busy_lu");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_LU,   1, "lu_after_busy");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN,  0, "run3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V_HALT, 1, "halt");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V_DRN,  1, "drain1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, V_DRN,  1, "drain2");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_DRN,  1, "drain3");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V_HLTD, 0, "halted_ignore");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V_HLTD, 0, "halted_hold");
        // Memory busy during drain stretches it by exactly two cycles.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RST,  0, "reset2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_CLR,  0, "clear2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN,  0, "run4");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V_HALT, 1, "halt2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_DRN,  1, "drain_b1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_DRNB, 1, "drain_busy1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_DRNB, 1, "drain_busy2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_DRN,  1, "drain_b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_DRN,  1, "drain_b3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_HLTD, 0, "halted_late");
        // Asynchronous reset asserted between edges in the middle of a drain.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RST,  0, "reset3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_CLR,  0, "clear3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, V_HALT, 1, "halt3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_DRN,  1, "drain_r1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RST,  0, "async_rst_mid_drain");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, V_RST,  0, "rst_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_CLR,  0, "clear4");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN,  0, "run5");
        // Twenty stall cycles: a 4-bit counter must saturate at 15.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_BUSY, 1, "sat_busy");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN,  0, "sat_final");
        @(negedge i_CLK); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
